// File: rtl/jtag_shift_engine.sv
// JTAG initiator: takes one command of up to 32 TMS/TDI bit pairs, generates TCK,
// shifts the bits LSB first and returns the captured TDO word. It can also issue TRST pulses.
module jtag_shift_engine #(
    parameter int CLK_DIV   = 4,
    parameter int TRST_TCKS = 8
) (
    input  logic        ps7_clk,
    input  logic        ps7_rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_trst_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [31:0] cmd_tms_i,
    input  logic [31:0] cmd_tdi_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_tdo_o,
    output logic        busy_o,
    output logic        tck_o,
    output logic        trst_no,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);
    localparam int DW       = $clog2(CLK_DIV + 1);
    localparam int TRST_CYC = TRST_TCKS * 2 * CLK_DIV;
    localparam int TW       = $clog2(TRST_CYC + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TRST_LAST = TW'(TRST_CYC - 1);

    typedef enum logic [2:0] {IDLE, LO, HI, TRST, RESP} state_t;

    typedef struct packed {
        logic [5:0]  last;
        logic [31:0] tms;
        logic [31:0] tdi;
    } cmd_t;

    state_t        state;
    cmd_t          cmd_q;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [TW-1:0] trst_cnt;
    logic [31:0]   tdo_q;

    logic [5:0] eff_len;
    logic [5:0] nxt_bit;
    assign eff_len = (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;
    assign nxt_bit = bit_cnt + 6'd1;

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state       <= IDLE;
            cmd_q       <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            trst_cnt    <= '0;
            tdo_q       <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_tdo_o   <= '0;
            busy_o      <= 1'b0;
            tck_o       <= 1'b0;
            trst_no     <= 1'b1;
            tms_o       <= 1'b0;
            tdi_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        trst_cnt    <= '0;
                        tdo_q       <= '0;
                        cmd_q       <= '{last: eff_len - 6'd1, tms: cmd_tms_i, tdi: cmd_tdi_i};
                        if (cmd_trst_i) begin
                            trst_no <= 1'b0;
                            state   <= TRST;
                        end else if (eff_len == 6'd0) begin
                            rsp_valid_o <= 1'b1;
                            rsp_tdo_o   <= '0;
                            state       <= RESP;
                        end else begin
                            tms_o <= cmd_tms_i[0];
                            tdi_o <= cmd_tdi_i[0];
                            state <= LO;
                        end
                    end
                end
                LO: begin
                    if (div_cnt == DIV_LAST) begin
                        // TDO was launched on the previous falling TCK edge, long settled by now
                        div_cnt               <= '0;
                        tck_o                 <= 1'b1;
                        tdo_q[bit_cnt[4:0]]   <= tdo_i;
                        state                 <= HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tck_o   <= 1'b0;
                        if (bit_cnt == cmd_q.last) begin
                            rsp_valid_o <= 1'b1;
                            rsp_tdo_o   <= tdo_q;
                            state       <= RESP;
                        end else begin
                            bit_cnt <= nxt_bit;
                            tms_o   <= cmd_q.tms[nxt_bit[4:0]];
                            tdi_o   <= cmd_q.tdi[nxt_bit[4:0]];
                            state   <= LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                TRST: begin
                    if (trst_cnt == TRST_LAST) begin
                        trst_no     <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        rsp_tdo_o   <= '0;
                        state       <= RESP;
                    end else begin
                        trst_cnt <= trst_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine (CLK_DIV=2): expected responses are queued at
// issue time and popped when the engine answers.
module tb_jtag_shift_engine;
    logic        ps7_clk = 1'b0;
    logic        ps7_rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_trst_i = 1'b0;
    logic [5:0]  cmd_len_i = '0;
    logic [31:0] cmd_tms_i = '0;
    logic [31:0] cmd_tdi_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_tdo_o;
    logic        busy_o;
    logic        tck_o;
    logic        trst_no;
    logic        tms_o;
    logic        tdi_o;
    logic        tdo_i;
    logic [1:0]  tdo_mode = 2'd0;   // 0: tie low, 1: tie high, 2: loop back tdi_o

    assign tdo_i = (tdo_mode == 2'd2) ? tdi_o : tdo_mode[0];

    jtag_shift_engine #(.CLK_DIV(2), .TRST_TCKS(8)) dut (
        .ps7_clk(ps7_clk), .ps7_rst_n(ps7_rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_trst_i(cmd_trst_i),
        .cmd_len_i(cmd_len_i), .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tdo_o(rsp_tdo_o),
        .busy_o(busy_o), .tck_o(tck_o), .trst_no(trst_no), .tms_o(tms_o),
        .tdi_o(tdi_o), .tdo_i(tdo_i)
    );

    always #5 ps7_clk = ~ps7_clk;

    typedef struct {
        logic [31:0] tdo;
        int          lat;
        int          tcks;
        int          trst_low;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   edge_n = 0;
    int   tck_rises = 0;
    int   trst_low = 0;
    logic prev_tck = 1'b0;
    int   acc_edge, rises0, trst0;

    always @(posedge ps7_clk) edge_n <= edge_n + 1;

    always @(negedge ps7_clk) begin
        if (tck_o && !prev_tck) tck_rises <= tck_rises + 1;
        if (!trst_no) trst_low <= trst_low + 1;
        prev_tck <= tck_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge ps7_clk);
        #1;
    endtask

    // Hold cmd_valid until accepted; records the accept edge.
    task automatic send(input logic trst, input logic [5:0] len, input logic [31:0] tms,
                        input logic [31:0] tdi, input exp_t e);
        logic rdy;
        bit   done = 0;
        cmd_valid_i = 1'b1; cmd_trst_i = trst; cmd_len_i = len;
        cmd_tms_i = tms; cmd_tdi_i = tdi;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = cmd_ready_o;
            step();
            if (rdy) begin
                done = 1;
                acc_edge = edge_n;
                rises0 = tck_rises;
                trst0 = trst_low;
            end
        end
        cmd_valid_i = 1'b0;
        cmd_tms_i = $urandom; cmd_tdi_i = $urandom; cmd_len_i = 6'($urandom);
        check("accept", 32'(done), 32'd1);
        exp_q.push_back(e);
    endtask

    task automatic collect(input string tag, input bit handshake);
        exp_t e;
        bit   seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            if (rsp_valid_o) seen = 1;
            else step();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        e = exp_q.pop_front();
        step();
        check({tag, "_lat"}, 32'(edge_n - 1 - acc_edge + 1), 32'(e.lat));
        check({tag, "_tdo"}, rsp_tdo_o, e.tdo);
        check({tag, "_tcks"}, 32'(tck_rises - rises0), 32'(e.tcks));
        check({tag, "_trst"}, 32'(trst_low - trst0), 32'(e.trst_low));
        if (handshake) begin
            rsp_ready_i = 1'b1;
            step();
            rsp_ready_i = 1'b0;
            check({tag, "_ready_after"}, 32'(cmd_ready_o), 32'd1);
            check({tag, "_valid_after"}, 32'(rsp_valid_o), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held;
        bit          hi_seen;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_tdo", rsp_tdo_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_tck", 32'(tck_o), 32'd0);
        check("rst_trst", 32'(trst_no), 32'd1);
        check("rst_tms", 32'(tms_o), 32'd0);
        check("rst_tdi", 32'(tdi_o), 32'd0);
        ps7_rst_n = 1'b1;
        step(); step();

        tdo_mode = 2'd0;
        send(0, 6'd5, 32'h1F, 32'h0, '{32'h0, 21, 5, 0});
        collect("len5", 1);
        check("len5_tms_hold", 32'(tms_o), 32'd1);

        tdo_mode = 2'd2;
        send(0, 6'd32, 32'h0, 32'hA5A51234, '{32'hA5A51234, 129, 32, 0});
        collect("len32", 1);

        send(0, 6'd0, 32'hFFFF, 32'hFFFF, '{32'h0, 1, 0, 0});
        collect("len0", 1);

        tdo_mode = 2'd1;
        send(0, 6'd40, 32'h0, 32'h0, '{32'hFFFFFFFF, 129, 32, 0});
        collect("len40", 1);

        send(0, 6'd3, 32'h0, 32'h0, '{32'h7, 13, 3, 0});
        collect("len3", 1);

        send(1, 6'd9, 32'hFF, 32'hFF, '{32'h0, 33, 0, 32});
        collect("trst", 1);
        check("trst_high_after", 32'(trst_no), 32'd1);

        // Backpressure with a second command waiting
        tdo_mode = 2'd2;
        send(0, 6'd4, 32'h0, 32'hA, '{32'hA, 17, 4, 0});
        collect("bp1", 0);
        held = rsp_tdo_o;
        cmd_valid_i = 1'b1; cmd_trst_i = 1'b0; cmd_len_i = 6'd2;
        cmd_tms_i = 32'h0; cmd_tdi_i = 32'h3;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_tdo_stable", rsp_tdo_o, held);
            check("bp_ready_low", 32'(cmd_ready_o), 32'd0);
            check("bp_tck_low", 32'(tck_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("bp_hs_ready", 32'(cmd_ready_o), 32'd1);
        check("bp_hs_valid", 32'(rsp_valid_o), 32'd0);
        step();
        acc_edge = edge_n; rises0 = tck_rises; trst0 = trst_low;
        cmd_valid_i = 1'b0;
        check("bp2_accepted", 32'(cmd_ready_o), 32'd0);
        check("bp2_busy", 32'(busy_o), 32'd1);
        exp_q.push_back('{32'h3, 9, 2, 0});
        collect("bp2", 1);

        // Reset during bit 10 high phase
        send(0, 6'd32, 32'h0, 32'hFFFF_FFFF, '{32'h0, 0, 0, 0});
        void'(exp_q.pop_back());
        hi_seen = 0;
        for (int i = 0; i < 200 && !hi_seen; i++) begin
            if (edge_n - acc_edge + 1 == 43) hi_seen = 1;
            else step();
        end
        check("mid_bit10_hi", 32'(tck_o), 32'd1);
        ps7_rst_n = 1'b0;
        #1;
        check("mid_rst_tck", 32'(tck_o), 32'd0);
        check("mid_rst_trst", 32'(trst_no), 32'd1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        step();
        ps7_rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(cmd_ready_o), 32'd1);
        check("post_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("post_rst_tdo", rsp_tdo_o, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
